// File: rtl/adc_scan_sequencer.sv
// rtl/adc_scan_sequencer.sv - round-robin SPI scan controller for an 8-channel 12-bit ADC
// Tracks the ADC's one-frame address pipeline and emits tagged result strobes.
module adc_scan_sequencer #(
  parameter int CLK_DIV = 13
) (
  input  logic        clock_50,
  input  logic        reset,
  input  logic        run,
  input  logic [7:0]  chan_mask,
  output logic        adc_cs_n,
  output logic        adc_sclk,
  output logic        adc_saddr,
  input  logic        adc_sdat,
  output logic        sample_valid,
  output logic [2:0]  sample_chan,
  output logic [11:0] sample_data,
  output logic        busy
);

  localparam logic [7:0] CNT_MAX = 8'(CLK_DIV - 1);

  typedef enum logic [2:0] {S_IDLE, S_SETUP, S_LOW, S_HIGH, S_QUIET} state_t;

  state_t      state_q;
  logic [7:0]  cnt_q;
  logic [3:0]  bit_q;
  logic [2:0]  addr_q, data_chan_q;
  logic        emit_ok_q, pend_q;
  logic [11:0] shift_q;
  logic        cs_n_q, sclk_q, saddr_q, valid_q, busy_q;
  logic [2:0]  chan_q;
  logic [11:0] data_q;

  logic        cnt_done;
  logic        keep_going;
  logic [2:0]  first_addr_d, next_addr_d;

  // Lowest enabled channel strictly above prev, wrapping; prev itself if it is the only one.
  function automatic logic [2:0] next_enabled(input logic [7:0] mask, input logic [2:0] prev);
    logic [2:0] r;
    logic [2:0] c;
    r = prev;
    for (int k = 7; k >= 0; k--) begin
      c = prev + 3'(k + 1);
      if (mask[c]) r = c;
    end
    return r;
  endfunction

  function automatic logic addr_bit(input logic [3:0] i, input logic [2:0] a);
    case (i)
      4'd2:    return a[2];
      4'd3:    return a[1];
      4'd4:    return a[0];
      default: return 1'b0;
    endcase
  endfunction

  assign cnt_done     = (cnt_q == CNT_MAX);
  assign keep_going   = run && (chan_mask != 8'd0);
  assign first_addr_d = next_enabled(chan_mask, 3'd7);
  assign next_addr_d  = next_enabled(chan_mask, addr_q);

  always_ff @(posedge clock_50 or posedge reset) begin
    if (reset) begin
      state_q     <= S_IDLE;
      cnt_q       <= 8'd0;
      bit_q       <= 4'd0;
      addr_q      <= 3'd0;
      data_chan_q <= 3'd0;
      emit_ok_q   <= 1'b0;
      pend_q      <= 1'b0;
      shift_q     <= 12'd0;
      cs_n_q      <= 1'b1;
      sclk_q      <= 1'b1;
      saddr_q     <= 1'b0;
      valid_q     <= 1'b0;
      busy_q      <= 1'b0;
      chan_q      <= 3'd0;
      data_q      <= 12'd0;
    end else begin
      // Strobe trails the final sample by one cycle so the shift register has settled.
      pend_q  <= 1'b0;
      valid_q <= pend_q;
      if (pend_q) begin
        chan_q <= data_chan_q;
        data_q <= shift_q;
      end
      cnt_q <= cnt_done ? 8'd0 : cnt_q + 8'd1;
      case (state_q)
        S_IDLE: begin
          cnt_q <= 8'd0;
          if (keep_going) begin
            state_q     <= S_SETUP;
            cs_n_q      <= 1'b0;
            busy_q      <= 1'b1;
            bit_q       <= 4'd0;
            saddr_q     <= 1'b0;
            addr_q      <= first_addr_d;
            data_chan_q <= 3'd0;
            emit_ok_q   <= chan_mask[0];
          end
        end
        S_SETUP: begin
          if (cnt_done) begin
            state_q <= S_LOW;
            sclk_q  <= 1'b0;
            saddr_q <= addr_bit(bit_q, addr_q);
          end
        end
        S_LOW: begin
          if (cnt_done) begin
            state_q <= S_HIGH;
            sclk_q  <= 1'b1;
            shift_q <= {shift_q[10:0], adc_sdat};
            if (bit_q == 4'd15) pend_q <= emit_ok_q;
          end
        end
        S_HIGH: begin
          if (cnt_done) begin
            if (bit_q != 4'd15) begin
              state_q <= S_LOW;
              sclk_q  <= 1'b0;
              bit_q   <= bit_q + 4'd1;
              saddr_q <= addr_bit(bit_q + 4'd1, addr_q);
            end else if (keep_going) begin
              state_q     <= S_LOW;
              sclk_q      <= 1'b0;
              bit_q       <= 4'd0;
              saddr_q     <= 1'b0;
              data_chan_q <= addr_q;
              emit_ok_q   <= 1'b1;
              addr_q      <= next_addr_d;
            end else begin
              state_q <= S_QUIET;
              cs_n_q  <= 1'b1;
              bit_q   <= 4'd0;
            end
          end
        end
        S_QUIET: begin
          if (cnt_done) begin
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign adc_cs_n     = cs_n_q;
  assign adc_sclk     = sclk_q;
  assign adc_saddr    = saddr_q;
  assign sample_valid = valid_q;
  assign sample_chan  = chan_q;
  assign sample_data  = data_q;
  assign busy         = busy_q;

endmodule

// File: doc/adc_scan_sequencer.md
# adc_scan_sequencer

Round-robin scan controller for the on-board 8-channel, 12-bit serial ADC (adc_cs_n / adc_sclk / adc_saddr / adc_sdat pins). It sequences back-to-back 16-bit SPI frames over the channels enabled in a mask. It tracks the ADC's one-frame address pipeline and presents each result as a tagged one-cycle strobe to the core logic.

## Interface
- CLK_DIV, 13: clock_50 cycles per SCLK half-period; legal range 2..255. The default gives 1.923 MHz SCLK.
- clock_50  input  1  system clock, 50 MHz.
- reset  input  1  asynchronous, active-high reset.
- run  input  1  level; scanning continues while high.
- chan_mask  input  8  bit n enables channel n.
- adc_cs_n  output  1  ADC chip select, active low.
- adc_sclk  output  1  ADC serial clock; idles high.
- adc_saddr  output  1  ADC DIN (address) line.
- adc_sdat  input  1  ADC DOUT line.
- sample_valid  output  1  one-cycle strobe marking a new result.
- sample_chan  output  3  channel of the result; held between strobes.
- sample_data  output  12  conversion result; held between strobes.
- busy  output  1  high from cs_n fall until the QUIET state exits.

## Operation
- States:
  - IDLE: cs_n=1, sclk=1.
  - SETUP: cs_n=0, lasts CLK_DIV cycles.
  - LOW: sclk=0, lasts CLK_DIV cycles.
  - HIGH: sclk=1, lasts CLK_DIV cycles.
  - QUIET: cs_n=1, lasts CLK_DIV cycles, then returns to IDLE.
- IDLE→SETUP when run=1 and chan_mask≠0. Otherwise the block stays in IDLE.
- A frame is 16 LOW/HIGH pairs, indexed by bit counter i=0..15.
- On entry to LOW i, drive adc_saddr to frame-word bit i. The word is MSB-first {0,0,A2,A1,A0,0,0,0,0…}: address bits appear at i=2,3,4 and the line is 0 elsewhere.
- Sample adc_sdat on each LOW→HIGH transition into a 16-bit shift register. The result is shift bits [11:0], i.e. the last 12 samples. The first 4 samples are ignored.
- Address pipeline: the data in frame k belongs to the channel addressed in frame k-1. The first frame after a cs_n fall returns channel 0.
- Addressing:
  - The address for frame k is the lowest enabled channel strictly above the frame k-1 address, wrapping from 7 to 0.
  - The first frame of a burst addresses the lowest enabled channel.
  - chan_mask is sampled only when the address is chosen, at SETUP entry or at the end of HIGH 15.
- Result strobe at the end of each frame:
  - sample_valid pulses, carrying the data channel.
  - For the first frame of a burst, the strobe fires only if chan_mask[0] was 1 at burst start.
  - For later frames, the strobe always fires, even if the mask has since dropped that channel.
- At the end of HIGH 15:
  - If run=1 and chan_mask≠0, go straight to LOW 0 of the next frame with cs_n held low (back-to-back).
  - Otherwise go to QUIET. The conversion addressed in the final frame is discarded.
- run falling mid-frame never truncates the frame. The frame finishes and its result is reported.
- Reset, asynchronous at any point including mid-frame, forces immediately:
  - cs_n=1, sclk=1, saddr=0.
  - sample_valid=0, sample_chan=0, sample_data=0.
  - busy=0, state IDLE, all counters 0.

## Timing
- cs_n falls 1 cycle after run=1 is sampled in IDLE.
- The first sclk fall occurs CLK_DIV cycles after cs_n falls.
- sclk rising edge i occurs (2i+2)·CLK_DIV cycles after the cs_n fall.
- sample_valid is high for exactly the 1 cycle after the sample at rising edge 15, i.e. at cs_n fall + 32·CLK_DIV + 1. sample_chan and sample_data update in that same cycle.
- Back-to-back frames repeat every 32·CLK_DIV cycles.
- From the last rising edge, cs_n rises after CLK_DIV cycles. It then stays high for at least CLK_DIV cycles before it can fall again.
- All outputs are registered. saddr changes only with an sclk fall, or with the cs_n fall for i=0.

## Test plan
- CLK_DIV=2, chan_mask=8'h01, run held high, ADC model returns 12'hA5C for ch0.
  - Required: every frame addresses 0.
  - Required: sample_valid every 64 cycles with chan=0, data=12'hA5C.
  - Required: the first strobe arrives 65 cycles after the cs_n fall.
- chan_mask=8'b1010_0100, run high for 5 frames.
  - Required addresses: 2,5,7,2,5.
  - Required strobes: (none for frame 0, since ch0 is disabled), 2, 5, 7, 2.
  - Required: cs_n low throughout, then a QUIET of 2 cycles.
- run dropped at bit 7 of frame 3 (mask 8'hFF).
  - Required: frame 3 completes and its strobe is reported for channel 2.
  - Required: cs_n rises 2 cycles after the last sclk rise.
  - Required: no further sclk edges.
- chan_mask changed from 8'h0F to 8'h30 mid-frame while address 1 is in flight.
  - Required: the next address is 4.
  - Required: the strobe for channel 1 is still delivered.
- reset asserted at bit 9 of a frame.
  - Required: cs_n=1, sclk=1, sample_valid=0 and data=0 in the same cycle as reset.
  - Required: after release, a fresh burst starts with ch0 pipeline handling.
- run=1 with chan_mask=0.
  - Required: the block stays in IDLE, cs_n stays 1, busy=0, no strobes for 1000 cycles.
